mpadd_serial: RTL
=================

// Module: mpadd_serial
//
// PURPOSE
//   Parametrised multi-precision adder/subtractor for the FFT datapath. It replaces the
//   fixed 256-bit combinational mpadd. Operands are loaded through the write/en_a/en_b
//   interface. On start, the block processes one LIMB_W-bit limb per cycle, LS limb first,
//   with a registered carry. It returns an N+1-bit result with a ready flag.
//
// PARAMETERS
//   N       256  operand width in bits; must satisfy N % LIMB_W == 0
//   LIMB_W  32   limb width processed per cycle (1..N)
//   NLIMB   N/LIMB_W  localparam, derived; number of limbs and of compute cycles
//
// PORTS
//   sys_clk   in   1      system clock; all logic on the rising edge
//   sys_rst   in   1      synchronous, active-high reset
//   write     in   1      operand load strobe
//   en_a      in   1      with write, load a_in into the A register
//   en_b      in   1      with write, load b_in into the B register
//   a_in      in   N      operand A
//   b_in      in   N      operand B
//   mode      in   1      0 = A+B, 1 = A-B; sampled on the cycle start is accepted
//   start     in   1      begin an operation (single-cycle pulse or level)
//   busy      out  1      high while in CALC
//   ready     out  1      high in DONE; s_out is valid
//   s_out     out  N+1    result; for sub, s_out[N] = borrow (1 means A<B)
//
// BEHAVIOUR
//   - Reset: state=IDLE; A, B, s_out, carry and limb counter all 0; busy=0, ready=0.
//     A reset in the middle of an operation aborts it and gives the same state.
//   - FSM IDLE -> CALC -> DONE. start in IDLE or DONE moves to CALC. DONE holds until start.
//   - Operand load: accepted in IDLE or DONE only. write&en_a: A<=a_in. write&en_b: B<=b_in.
//     Both may be set in the same cycle. write, start and mode are all ignored in CALC.
//   - Same-cycle write+start: the values being written are the ones used for the operation.
//   - Start accept: the working shift copies are taken from the post-write A and B values.
//     carry <= mode; cnt <= 0; mode is latched; ready drops and busy rises on the next edge.
//   - CALC, per cycle i = cnt:
//       {c, r_i} = A_i + (B_i ^ {LIMB_W{mode}}) + carry
//     r_i is shifted into the MS end of the result shift register; carry <= c;
//     the working copies shift right by LIMB_W.
//     The compute path is LIMB_W+1 bits wide; there is no N-bit carry chain.
//   - At the cnt == NLIMB-1 edge: move to DONE.
//     s_out[N-1:0] <= result register with the final limb included.
//     s_out[N] <= c for add, ~c for sub.
//   - s_out is updated only on entry to DONE. It holds the previous result through IDLE and
//     CALC and changes only on completion or reset.
//   - Latency: start sampled at edge t gives ready=1 after edge t+NLIMB (NLIMB+1 cycles).
//     Back-to-back: start in DONE restarts immediately. Throughput is 1 op per NLIMB+1 cycles.
//   - Wrap-around: the add carry-out and the sub borrow are both captured in s_out[N].
//     The N-bit field is the result modulo 2^N.
//
// TESTING (N=256, LIMB_W=32 unless noted)
//   1. Reset held 2 cycles -> ready=0, busy=0, s_out=0. A start issued during reset is ignored.
//   2. A=2^256-1, B=1, add, start at edge t -> busy during t+1..t+8;
//      ready=1 after edge t+8; s_out=2^256 (carry ripples through all 8 limbs).
//   3. A=5, B=7, sub -> s_out={1'b1, 2^256-2}.
//      A=7, B=5, sub -> s_out=2.
//   4. write&en_a&en_b&start in one cycle with a_in=0x1234, b_in=0x1 -> s_out=0x1235.
//      A later write&en_a with 0 while in DONE leaves s_out unchanged.
//   5. During CALC, pulse start, flip mode, and write a_in=0 -> result is unaffected and
//      latency is unchanged. Then reset mid-CALC -> next cycle is IDLE, s_out=0, ready=0.
//   6. LIMB_W=256 (NLIMB=1): A=B=2^255 add -> ready after 1 compute cycle, s_out=2^256.
//      LIMB_W=8: random add/sub sweep against an (N+1)-bit reference model.

Source files
------------

// File: rtl/mpadd_serial.sv
// Serial multi-precision adder/subtractor: one LIMB_W-bit limb per cycle, LS limb first,
// with a registered carry between limbs and an (N+1)-bit registered result.
module mpadd_serial #(
    parameter int N      = 256,
    parameter int LIMB_W = 32
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         write,
    input  logic         en_a,
    input  logic         en_b,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic         mode,
    input  logic         start,
    output logic         busy,
    output logic         ready,
    output logic [N:0]   s_out
);
    localparam int NLIMB = N / LIMB_W;
    localparam int CNT_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [N-1:0]       a_q, b_q;
    logic [N-1:0]       wa_q, wb_q;
    logic [N-1:0]       res_q;
    logic               carry_q;
    logic               mode_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, ready_q;
    logic [N:0]         s_out_q;

    logic [N-1:0]       a_d, b_d;
    logic [N-1:0]       wa_d, wb_d;
    logic [N-1:0]       res_d;
    logic [LIMB_W:0]    limb_sum;
    logic               last_limb;
    logic               load_ok;

    // Operands written in the same cycle as start must feed the operation.
    assign a_d = (write && en_a) ? a_in : a_q;
    assign b_d = (write && en_b) ? b_in : b_q;

    // Only LIMB_W+1 bits of carry chain: the carry between limbs is registered.
    assign limb_sum = {1'b0, wa_q[LIMB_W-1:0]}
                    + {1'b0, wb_q[LIMB_W-1:0] ^ {LIMB_W{mode_q}}}
                    + {{LIMB_W{1'b0}}, carry_q};

    generate
        if (LIMB_W == N) begin : g_single_limb
            assign res_d = limb_sum[LIMB_W-1:0];
            assign wa_d  = '0;
            assign wb_d  = '0;
        end else begin : g_multi_limb
            assign res_d = {limb_sum[LIMB_W-1:0], res_q[N-1:LIMB_W]};
            assign wa_d  = {{LIMB_W{1'b0}}, wa_q[N-1:LIMB_W]};
            assign wb_d  = {{LIMB_W{1'b0}}, wb_q[N-1:LIMB_W]};
        end
    endgenerate

    assign last_limb = (cnt_q == CNT_W'(NLIMB - 1));
    assign load_ok   = (state_q == IDLE) || (state_q == DONE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            wa_q    <= '0;
            wb_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            s_out_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    a_q <= a_d;
                    b_q <= b_d;
                    if (start) begin
                        wa_q    <= a_d;
                        wb_q    <= b_d;
                        carry_q <= mode;
                        mode_q  <= mode;
                        cnt_q   <= '0;
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                CALC: begin
                    wa_q    <= wa_d;
                    wb_q    <= wb_d;
                    res_q   <= res_d;
                    carry_q <= limb_sum[LIMB_W];
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_limb) begin
                        // Sub reports borrow, which is the inverted carry of A + ~B + 1.
                        s_out_q <= {limb_sum[LIMB_W] ^ mode_q, res_d};
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign ready = ready_q;
    assign s_out = s_out_q;

    // load_ok documents when operand writes take effect; the case arms implement it.
    logic unused_ok;
    assign unused_ok = load_ok;

endmodule
